branch_u: RTL and testbench
===========================

BRANCH_U -- requirements
Module: branch_u

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width for operands, pc, immediate and results.
REQ-002 SHALL have parameter BYPASS_WID, default 4, meaning number of bypass data sources; select width is $clog2(BYPASS_WID).
REQ-003 SHALL have parameter OUTQ_DEPTH, default 2 (minimum 1), meaning writeback result queue entries.
REQ-004 SHALL have ports: clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port i_vld  in  1  issue valid.
REQ-007 SHALL have port o_rdy  out  1  unit can accept an issue this cycle.
REQ-008 SHALL have port i_fuInfo  in  fuInfo_t  micOp, robIdx, iprd_wen, iprd_idx, use_imm, immBIdx.
REQ-009 SHALL have ports i_data[BYPASS_WID]  in  XLEN each; i_data_idx[2]  in  $clog2(BYPASS_WID) each.
REQ-010 SHALL have ports i_imm  in  XLEN  sign-extended immediate; i_pc  in  XLEN; i_predTakenpc  in  XLEN  predicted next pc.
REQ-011 SHALL have port i_flush  in  1  discard all in-flight work.
REQ-012 SHALL have port i_wb_stall  in  1  writeback port blocked.
REQ-013 SHALL have ports o_complete  out  1; o_wbInfo  out  wbInfo_t.
REQ-014 SHALL have ports o_redirect_vld  out  1; o_redirect  out  redirectInfo_t  robIdx, taken, target (XLEN).

Function
REQ-015 Issue SHALL be accepted when i_vld && o_rdy && !i_flush; stage-1 register captures fuInfo, data_idx, imm, pc, predTakenpc.
REQ-016 Operands SHALL be read one cycle after acceptance: src0/src1 = i_data[saved_data_idx[0/1]].
REQ-017 Stage 1 SHALL compute in that cycle and push one entry into the output queue at the following edge (accept-to-o_complete latency 2 cycles, queue empty, no stall).
REQ-018 micOp jal: target = pc+imm; jalr: target = (src0+imm) with bit 0 cleared; both taken=1, wb_data = pc+4.
REQ-019 micOp beq/bne/blt/bge/bltu/bgeu: signed compares for blt/bge, unsigned for bltu/bgeu; target = taken ? pc+imm : pc+4; no register write.
REQ-020 micOp auipc: wb_data = pc+imm; no redirect check.
REQ-021 All additions SHALL be modulo 2^XLEN.
REQ-022 Mispredict = (target != predTakenpc) for jal/jalr/branches; on mispredict o_redirect_vld SHALL pulse exactly one cycle, registered, aligned with queue push, independent of i_wb_stall.
REQ-023 Queue head SHALL drive o_complete (=not empty) and o_wbInfo; pop on o_complete && !i_wb_stall.
REQ-024 o_rdy SHALL equal (queue count + stage-1 valid) < OUTQ_DEPTH, or that sum == OUTQ_DEPTH with a pop this cycle (credit, combinational, no issue lost).
REQ-025 Simultaneous push and pop at full SHALL be legal; queue pointers wrap at OUTQ_DEPTH.
REQ-026 i_flush SHALL clear stage-1 valid, queue count and pointers at the next edge; the redirect pulse of a flushed op SHALL be suppressed; o_complete low the cycle after flush.
REQ-027 Unknown micOp SHALL complete with wb_data = 0, iprd_wen forced 0, no redirect.

Reset
REQ-028 While rst low: o_complete=0, o_redirect_vld=0, stage-1 valid=0, queue empty, o_rdy=1 after deassertion; datapath payload registers not reset.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries immediately (asynchronous).

Structure
REQ-030 fuInfo_t, wbInfo_t, redirectInfo_t and MicOp_t SHALL live in the shared fu package/define header.
REQ-031 Output queue SHALL be sub-module fu_outq (parametrised depth, payload type).

Verification
REQ-032 beq, src0=src1=5, pc=0x1000, imm=0x40, pred=0x1040 -> complete at +2 cycles, no redirect.
REQ-033 bltu, src0=1, src1=0xFFFF_FFFF_FFFF_FFFF, pred=0x1004, pc=0x1000, imm=0x40 -> redirect target 0x1040, taken=1; blt same operands -> not taken, no redirect.
REQ-034 jalr src0=0x2001, imm=0x2, pred=0x2002, pc=0x3000 -> target 0x2002 no redirect, wb_data 0x3004.
REQ-035 i_wb_stall held 5 cycles with back-to-back auipc issues, OUTQ_DEPTH=2 -> o_rdy drops after 2 accepts, results drain in order, none lost or duplicated.
REQ-036 i_flush same cycle as i_vld with mispredicting jal in stage 1 -> no redirect pulse, o_complete 0 next cycle, new issue accepted following cycle.
REQ-037 rst pulsed low with full queue -> outputs zero immediately, o_rdy=1 after release.

Source files
------------

// File: rtl/branch_u_pkg.sv
// Shared functional-unit types: micro-op encoding, issue info, writeback and redirect payloads.
package branch_u_pkg;

    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned ROB_W    = 6;
    localparam int unsigned PRD_W    = 7;
    localparam int unsigned IMMB_W   = 4;

    typedef enum logic [3:0] {
        MICOP_JAL   = 4'd1,
        MICOP_JALR  = 4'd2,
        MICOP_BEQ   = 4'd3,
        MICOP_BNE   = 4'd4,
        MICOP_BLT   = 4'd5,
        MICOP_BGE   = 4'd6,
        MICOP_BLTU  = 4'd7,
        MICOP_BGEU  = 4'd8,
        MICOP_AUIPC = 4'd9
    } MicOp_t;

    typedef struct packed {
        MicOp_t              micOp;
        logic [ROB_W-1:0]    robIdx;
        logic                iprd_wen;
        logic [PRD_W-1:0]    iprd_idx;
        logic                use_imm;
        logic [IMMB_W-1:0]   immBIdx;
    } fuInfo_t;

    typedef struct packed {
        logic [ROB_W-1:0]    robIdx;
        logic                iprd_wen;
        logic [PRD_W-1:0]    iprd_idx;
        logic [XLEN_MAX-1:0] wb_data;
    } wbInfo_t;

    typedef struct packed {
        logic [ROB_W-1:0]    robIdx;
        logic                taken;
        logic [XLEN_MAX-1:0] target;
    } redirectInfo_t;

endpackage

// File: rtl/fu_outq.sv
// Small circular result queue; push and pop in the same cycle are legal even when full.
module fu_outq #(
    parameter int unsigned DEPTH = 2,
    parameter type T = logic,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  T                 i_data,
    input  logic             i_pop,
    output logic             o_vld,
    output T                 o_data,
    output logic [CNT_W-1:0] o_count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        pop_ok   = i_pop && (count_q != '0);
        push_ok  = i_push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_ok && !i_flush) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_vld   = (count_q != '0);
    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/branch_u.sv
// Branch/jump unit: one-stage compute after issue, mispredict redirect pulse, queued writeback.
module branch_u
    import branch_u_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned BYPASS_WID = 4,
    parameter int unsigned OUTQ_DEPTH = 2,
    localparam int unsigned SEL_W     = (BYPASS_WID > 1) ? $clog2(BYPASS_WID) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    output logic              o_rdy,
    input  fuInfo_t           i_fuInfo,
    input  logic [XLEN-1:0]   i_data [BYPASS_WID],
    input  logic [SEL_W-1:0]  i_data_idx [2],
    input  logic [XLEN-1:0]   i_imm,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_predTakenpc,
    input  logic              i_flush,
    input  logic              i_wb_stall,
    output logic              o_complete,
    output wbInfo_t           o_wbInfo,
    output logic              o_redirect_vld,
    output redirectInfo_t     o_redirect
);
    localparam int unsigned CNT_W = $clog2(OUTQ_DEPTH + 1);

    logic             s1_vld_q, s1_vld_d;
    fuInfo_t          fu_q, fu_d;
    logic [SEL_W-1:0] idx_q [2];
    logic [SEL_W-1:0] idx_d [2];
    logic [XLEN-1:0]  imm_q, imm_d, pc_q, pc_d, pred_q, pred_d;
    logic             redir_vld_q, redir_vld_d;
    redirectInfo_t    redir_q, redir_d;

    logic             accept, push, pop, check, taken, wb_wen;
    logic [XLEN-1:0]  src0, src1, pc_imm, pc_4, target, wb_data;
    logic [CNT_W:0]   occ;
    logic [CNT_W-1:0] q_count;
    logic             q_vld;
    wbInfo_t          wb_c;
    logic             unused_fu;

    assign unused_fu = ^{fu_q.use_imm, fu_q.immBIdx};

    // Stage-1 compute: operands come from the bypass network one cycle after issue.
    always_comb begin
        src0    = i_data[idx_q[0]];
        src1    = i_data[idx_q[1]];
        pc_imm  = pc_q + imm_q;
        pc_4    = pc_q + XLEN'(4);
        taken   = 1'b0;
        target  = pc_4;
        wb_data = '0;
        wb_wen  = 1'b0;
        check   = 1'b0;
        case (fu_q.micOp)
            MICOP_JAL: begin
                taken   = 1'b1;
                target  = pc_imm;
                wb_data = pc_4;
                wb_wen  = fu_q.iprd_wen;
                check   = 1'b1;
            end
            MICOP_JALR: begin
                taken   = 1'b1;
                target  = (src0 + imm_q) & ~XLEN'(1);
                wb_data = pc_4;
                wb_wen  = fu_q.iprd_wen;
                check   = 1'b1;
            end
            MICOP_BEQ, MICOP_BNE, MICOP_BLT, MICOP_BGE, MICOP_BLTU, MICOP_BGEU: begin
                check = 1'b1;
                case (fu_q.micOp)
                    MICOP_BEQ:  taken = (src0 == src1);
                    MICOP_BNE:  taken = (src0 != src1);
                    MICOP_BLT:  taken = ($signed(src0) < $signed(src1));
                    MICOP_BGE:  taken = !($signed(src0) < $signed(src1));
                    MICOP_BLTU: taken = (src0 < src1);
                    MICOP_BGEU: taken = !(src0 < src1);
                    default:    taken = 1'b0;
                endcase
                target = taken ? pc_imm : pc_4;
            end
            MICOP_AUIPC: begin
                wb_data = pc_imm;
                wb_wen  = fu_q.iprd_wen;
            end
            default: ;
        endcase
    end

    // Issue credit, stage-1 capture, queue push and redirect generation.
    always_comb begin
        pop         = q_vld && !i_wb_stall;
        occ         = (CNT_W + 1)'(q_count) + (CNT_W + 1)'(s1_vld_q);
        o_rdy       = (occ < (CNT_W + 1)'(OUTQ_DEPTH)) ||
                      ((occ == (CNT_W + 1)'(OUTQ_DEPTH)) && pop);
        accept      = i_vld && o_rdy && !i_flush;
        push        = s1_vld_q && !i_flush;
        s1_vld_d    = accept;
        fu_d        = fu_q;
        idx_d       = idx_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        pred_d      = pred_q;
        redir_d     = redir_q;
        redir_vld_d = push && check && (target != pred_q);
        if (accept) begin
            fu_d   = i_fuInfo;
            idx_d  = i_data_idx;
            imm_d  = i_imm;
            pc_d   = i_pc;
            pred_d = i_predTakenpc;
        end
        if (push) begin
            redir_d.robIdx = fu_q.robIdx;
            redir_d.taken  = taken;
            redir_d.target = XLEN_MAX'(target);
        end
        wb_c.robIdx   = fu_q.robIdx;
        wb_c.iprd_wen = wb_wen;
        wb_c.iprd_idx = fu_q.iprd_idx;
        wb_c.wb_data  = XLEN_MAX'(wb_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q    <= 1'b0;
            redir_vld_q <= 1'b0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            redir_vld_q <= redir_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        fu_q    <= fu_d;
        idx_q   <= idx_d;
        imm_q   <= imm_d;
        pc_q    <= pc_d;
        pred_q  <= pred_d;
        redir_q <= redir_d;
    end

    fu_outq #(
        .DEPTH (OUTQ_DEPTH),
        .T     (wbInfo_t)
    ) u_outq (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_flush),
        .i_push  (push),
        .i_data  (wb_c),
        .i_pop   (pop),
        .o_vld   (q_vld),
        .o_data  (o_wbInfo),
        .o_count (q_count)
    );

    assign o_complete     = q_vld;
    assign o_redirect_vld = redir_vld_q;
    assign o_redirect     = redir_q;

endmodule

// File: tb/tb_branch_u.sv
// Randomized + directed bench for branch_u against a queue-based reference model.
module tb_branch_u;
    import branch_u_pkg::*;

    localparam int unsigned BW    = 4;
    localparam int unsigned DEPTH = 2;

    typedef struct {
        fuInfo_t     fu;
        logic [1:0]  idx0, idx1;
        logic [63:0] imm, pc, pred;
    } op_t;

    typedef struct {
        wbInfo_t       wb;
        bit            chk_data;
        bit            redir;
        redirectInfo_t rd;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_vld, o_rdy, i_flush, i_wb_stall, o_complete, o_redirect_vld;
    fuInfo_t       i_fuInfo;
    logic [63:0]   i_data [BW];
    logic [1:0]    i_data_idx [2];
    logic [63:0]   i_imm, i_pc, i_pred;
    wbInfo_t       o_wbInfo;
    redirectInfo_t o_redirect;

    logic [63:0]   nxt_data [BW];
    op_t           s1_q [$];
    res_t          outq [$];
    bit            exp_redir;
    redirectInfo_t exp_rd;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    branch_u #(.XLEN(64), .BYPASS_WID(BW), .OUTQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_vld(i_vld), .o_rdy(o_rdy), .i_fuInfo(i_fuInfo),
        .i_data(i_data), .i_data_idx(i_data_idx), .i_imm(i_imm), .i_pc(i_pc),
        .i_predTakenpc(i_pred), .i_flush(i_flush), .i_wb_stall(i_wb_stall),
        .o_complete(o_complete), .o_wbInfo(o_wbInfo),
        .o_redirect_vld(o_redirect_vld), .o_redirect(o_redirect)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result of one op given the operand values seen in its execute cycle.
    function automatic res_t ref_exec(op_t op, logic [63:0] s0, logic [63:0] s1);
        res_t r;
        logic [63:0] seq, rel, tgt;
        bit tk = 0, ctl = 0, br = 0;
        seq = op.pc + 64'd4;
        rel = op.pc + op.imm;
        tgt = seq;
        r.wb.robIdx   = op.fu.robIdx;
        r.wb.iprd_idx = op.fu.iprd_idx;
        r.wb.iprd_wen = 1'b0;
        r.wb.wb_data  = '0;
        r.chk_data    = 1;
        case (op.fu.micOp)
            MICOP_JAL:   begin ctl = 1; tk = 1; tgt = rel; r.wb.wb_data = seq; r.wb.iprd_wen = op.fu.iprd_wen; end
            MICOP_JALR:  begin ctl = 1; tk = 1; tgt = (s0 + op.imm) & ~64'd1; r.wb.wb_data = seq; r.wb.iprd_wen = op.fu.iprd_wen; end
            MICOP_BEQ:   begin br = 1; tk = (s0 == s1); end
            MICOP_BNE:   begin br = 1; tk = (s0 != s1); end
            MICOP_BLT:   begin br = 1; tk = ($signed(s0) < $signed(s1)); end
            MICOP_BGE:   begin br = 1; tk = ($signed(s0) >= $signed(s1)); end
            MICOP_BLTU:  begin br = 1; tk = (s0 < s1); end
            MICOP_BGEU:  begin br = 1; tk = (s0 >= s1); end
            MICOP_AUIPC: begin r.wb.wb_data = rel; r.wb.iprd_wen = op.fu.iprd_wen; end
            default: ;
        endcase
        if (br) begin
            ctl = 1;
            r.chk_data = 0;
            tgt = tk ? rel : seq;
        end
        r.redir     = ctl && (tgt != op.pred);
        r.rd.robIdx = op.fu.robIdx;
        r.rd.taken  = tk;
        r.rd.target = tgt;
        return r;
    endfunction

    function automatic op_t mk_op(MicOp_t m, logic [63:0] imm, logic [63:0] pc, logic [63:0] pred);
        op_t o;
        o.fu.micOp    = m;
        o.fu.robIdx   = 6'($urandom);
        o.fu.iprd_wen = 1'b1;
        o.fu.iprd_idx = 7'($urandom);
        o.fu.use_imm  = 1'b0;
        o.fu.immBIdx  = '0;
        o.idx0 = 2'd0;
        o.idx1 = 2'd1;
        o.imm  = imm;
        o.pc   = pc;
        o.pred = pred;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        logic [11:0] r12;
        r12 = 12'($urandom);
        o = mk_op(MicOp_t'(4'($urandom_range(1, 9))), {{52{r12[11]}}, r12}, {$urandom, $urandom}, 64'd0);
        if ($urandom_range(0, 4) == 0) o.fu.micOp = MicOp_t'(4'($urandom_range(0, 15)));
        o.fu.iprd_wen = 1'($urandom);
        o.fu.use_imm  = 1'($urandom);
        o.fu.immBIdx  = 4'($urandom);
        o.idx0 = 2'($urandom);
        o.idx1 = 2'($urandom);
        case ($urandom_range(0, 2))
            0:       o.pred = o.pc + o.imm;
            1:       o.pred = o.pc + 64'd4;
            default: o.pred = {$urandom, $urandom};
        endcase
        return o;
    endfunction

    // One clock cycle: drive at negedge, check outputs, then advance the model across the posedge.
    task automatic step(input bit vld, input op_t op, input bit flush, input bit stall, input bit rnd, output bit acc);
        int occ;
        bit pop, exp_rdy;
        res_t r;
        @(negedge clk);
        for (int k = 0; k < BW; k++) begin
            if (rnd) begin
                case ($urandom_range(0, 3))
                    0:       nxt_data[k] = {$urandom, $urandom};
                    1:       nxt_data[k] = 64'($urandom_range(0, 3));
                    2:       nxt_data[k] = '1;
                    default: nxt_data[k] = 64'h8000_0000_0000_0000;
                endcase
            end
            i_data[k] = nxt_data[k];
        end
        i_vld = vld; i_fuInfo = op.fu; i_data_idx[0] = op.idx0; i_data_idx[1] = op.idx1;
        i_imm = op.imm; i_pc = op.pc; i_pred = op.pred; i_flush = flush; i_wb_stall = stall;
        #1;
        occ     = outq.size() + s1_q.size();
        pop     = (outq.size() > 0) && !stall;
        exp_rdy = (occ < DEPTH) || ((occ == DEPTH) && pop);
        chk("o_rdy", o_rdy, exp_rdy);
        chk("o_complete", o_complete, outq.size() > 0);
        if (outq.size() > 0) begin
            chk("wb_robIdx", o_wbInfo.robIdx, outq[0].wb.robIdx);
            chk("wb_wen", o_wbInfo.iprd_wen, outq[0].wb.iprd_wen);
            chk("wb_prd", o_wbInfo.iprd_idx, outq[0].wb.iprd_idx);
            if (outq[0].chk_data) chk("wb_data", o_wbInfo.wb_data, outq[0].wb.wb_data);
        end
        chk("redirect_vld", o_redirect_vld, exp_redir);
        if (exp_redir) begin
            chk("redir_rob", o_redirect.robIdx, exp_rd.robIdx);
            chk("redir_taken", o_redirect.taken, exp_rd.taken);
            chk("redir_target", o_redirect.target, exp_rd.target);
        end
        acc = vld && o_rdy && !flush;
        exp_redir = 0;
        if (flush) begin
            s1_q.delete();
            outq.delete();
        end else begin
            if (pop) void'(outq.pop_front());
            if (s1_q.size() > 0) begin
                r = ref_exec(s1_q[0], i_data[s1_q[0].idx0], i_data[s1_q[0].idx1]);
                outq.push_back(r);
                exp_redir = r.redir;
                exp_rd    = r.rd;
                s1_q.delete();
            end
            if (vld && exp_rdy) s1_q.push_back(op);
        end
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_complete", o_complete, 1'b0);
        chk("rst_redirect", o_redirect_vld, 1'b0);
        s1_q.delete();
        outq.delete();
        exp_redir = 0;
        i_vld = 1'b0;
        i_flush = 1'b0;
        i_wb_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit a;
        int n;
        op_t idle;
        rst = 1'b0; i_vld = 1'b0; i_flush = 1'b0; i_wb_stall = 1'b0; i_fuInfo = '0;
        i_imm = '0; i_pc = '0; i_pred = '0; i_data_idx[0] = '0; i_data_idx[1] = '0;
        for (int k = 0; k < BW; k++) begin i_data[k] = '0; nxt_data[k] = '0; end
        exp_redir = 0;
        idle = mk_op(MICOP_AUIPC, 64'd0, 64'd0, 64'd0);
        #1;
        chk("reset_complete", o_complete, 1'b0);
        chk("reset_redirect", o_redirect_vld, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // beq taken, correctly predicted
        nxt_data[0] = 64'd5; nxt_data[1] = 64'd5;
        step(1, mk_op(MICOP_BEQ, 64'h40, 64'h1000, 64'h1040), 0, 0, 0, a);
        repeat (3) step(0, idle, 0, 0, 0, a);

        // bltu taken and mispredicted, then blt on the same operands not taken
        nxt_data[0] = 64'd1; nxt_data[1] = '1;
        step(1, mk_op(MICOP_BLTU, 64'h40, 64'h1000, 64'h1004), 0, 0, 0, a);
        step(1, mk_op(MICOP_BLT, 64'h40, 64'h1000, 64'h1004), 0, 0, 0, a);
        repeat (3) step(0, idle, 0, 0, 0, a);

        // jalr clears target bit 0
        nxt_data[0] = 64'h2001;
        step(1, mk_op(MICOP_JALR, 64'h2, 64'h3000, 64'h2002), 0, 0, 0, a);
        repeat (3) step(0, idle, 0, 0, 0, a);

        // back-to-back auipc under a 5-cycle writeback stall
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, mk_op(MICOP_AUIPC, 64'(i * 8), 64'(32'h4000 + i * 16), 64'd0), 0, 1, 0, a);
            n += int'(a);
        end
        chk("stall_accepts", 32'(n), 32'd2);
        repeat (4) step(0, idle, 0, 0, 0, a);

        // flush with a mispredicting jal in stage 1
        step(1, mk_op(MICOP_JAL, 64'h100, 64'h5000, 64'h5004), 0, 0, 0, a);
        step(1, mk_op(MICOP_AUIPC, 64'h8, 64'h6000, 64'd0), 1, 0, 0, a);
        step(1, mk_op(MICOP_AUIPC, 64'h10, 64'h7000, 64'd0), 0, 0, 0, a);
        chk("post_flush_accept", a, 1'b1);
        repeat (3) step(0, idle, 0, 0, 0, a);

        // asynchronous reset with a full queue
        step(1, mk_op(MICOP_AUIPC, 64'h4, 64'h8000, 64'd0), 0, 1, 0, a);
        step(1, mk_op(MICOP_AUIPC, 64'h8, 64'h8100, 64'd0), 0, 1, 0, a);
        repeat (2) step(0, idle, 0, 1, 0, a);
        chk("full_before_rst", o_complete, 1'b1);
        reset_mid();
        step(0, idle, 0, 0, 0, a);
        chk("rdy_after_rst", o_rdy, 1'b1);

        // randomized traffic with stalls, flushes and occasional resets
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 9) < 7, rand_op(), $urandom_range(0, 31) == 0,
                 $urandom_range(0, 9) < 3, 1, a);
            if (c % 500 == 499) reset_mid();
        end
        repeat (4) step(0, idle, 0, 0, 1, a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
